round_share_arb: RTL and testbench
==================================

Name: round_share_arb

Overview:
- Shares one normalization-shift/rounding datapath between up to NREQ floating-point producers (adder, multiplier, divider).
- Performs round-robin arbitration and registers the winning operand set into the shared datapath's input.
- Tracks in-flight requester IDs across the datapath's fixed latency and tags returning results.
- Sequences OVFen/UNFen configuration changes so they never apply while operations are in flight.

Parameters:
- NREQ, 3, number of requesters (2..4)
- ID_W, 2, width of requester ID; must satisfy 2^ID_W >= NREQ
- LAT, 3, fixed latency in cycles of the shared datapath from iss_valid to its result (1..8)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req  in  NREQ  request per requester; held with operands stable until granted
- fr_in  in  NREQ*57  significands, requester i at [57*i+56:57*i]
- er_in  in  NREQ*13  exponents, requester i at [13*i+12:13*i]
- db_in  in  NREQ  double-precision flag per requester
- gnt  out  NREQ  one-hot grant pulse, registered
- iss_valid  out  1  operand valid to the shared datapath
- iss_fr  out  57  granted significand
- iss_er  out  13  granted exponent
- iss_db  out  1  granted precision flag
- iss_id  out  ID_W  granted requester index
- res_valid  out  1  high exactly LAT cycles after a non-flushed iss_valid
- res_id  out  ID_W  requester index for the result currently leaving the datapath
- flush  in  1  kill all in-flight tags
- cfg_we  in  1  request configuration update
- cfg_ovfen  in  1  new OVFen value
- cfg_unfen  in  1  new UNFen value
- OVFen  out  1  applied overflow-trap enable to the datapath
- UNFen  out  1  applied underflow-trap enable to the datapath
- busy  out  1  any tag in flight, or state is not RUN

Behaviour:
- Reset values: gnt=0, iss_valid=0, iss_fr/er/db/id=0, res_valid=0, res_id=0, OVFen=0, UNFen=0, state=RUN, round-robin pointer=0, all tags invalid, pending config cleared.
- Arbitration:
  - In RUN, each cycle selects the first asserted req starting at pointer, wrapping modulo NREQ.
  - On the next edge: gnt[i]=1 for one cycle; iss_* latch requester i's operands; iss_valid=1; pointer becomes (i+1) mod NREQ.
  - Grant-to-issue latency is 1 cycle; gnt and iss_valid are coincident.
  - A requester samples gnt high and may drop or change req and operands in the following cycle.
  - A single requester asserting req continuously is granted every other cycle: its req is still high the cycle gnt pulses and is masked that cycle, so there is no double grant.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}, loaded from {iss_valid, iss_id}.
  - res_valid/res_id are the last stage.
  - Tag throughput is one per cycle.
- flush:
  - Clears all tag valids on the next edge.
  - Suppresses any grant in the same cycle, so gnt=0 and iss_valid=0 next cycle.
  - Leaves the pointer unchanged.
  - No res_valid appears for issues made before the flush.
- Configuration state machine:
  - RUN: grants allowed. cfg_we=1 captures cfg_ovfen/cfg_unfen into the pending register and moves to DRAIN. No grant is made in the cfg_we cycle.
  - DRAIN: no grants. A cfg_we here overwrites the pending value (last write wins). When no tag is valid, moves to APPLY.
  - APPLY: one cycle. OVFen/UNFen take the pending values on its exit edge; then returns to RUN.
  - Minimum RUN->RUN with an empty pipeline is 3 cycles.
  - A flush during DRAIN empties the pipeline and proceeds to APPLY on the next cycle.
- busy is combinational from the registered state and tag valids.
- Mid-operation reset clears everything immediately, asynchronously; in-flight results are lost.

Optional Feature:
- RND_ARB_PERF_CNT_EN.
- When defined: adds a 32-bit saturating grant counter per requester, and a 32-bit stall counter incremented on each cycle where some req is high but no grant issues. Counters reset to 0 and are exposed on output perf_cnt[(NREQ+1)*32-1:0], stall counter in the top word.
- When undefined: no counters and no perf_cnt port.

Test Plan:
- Reset, then req=3'b111 held for 6 cycles -> gnt sequence 001,010,100,001,010,100; res_valid with res_id 0,1,2,... starting 3 cycles after each gnt (LAT=3).
- req=3'b001 only, held continuously -> gnt[0] on alternate cycles; iss_fr equals fr_in[56:0] at each grant.
- Issue 3 back-to-back grants, then flush 1 cycle after the last -> zero res_valid pulses afterward; the flush cycle grants nothing.
- cfg_we with ovfen=1, unfen=1 while 2 tags are in flight -> no gnt until both results drain; OVFen=UNFen=1 one cycle after the pipeline empties; then arbitration resumes at the saved pointer.
- Two cfg_we pulses in DRAIN (values 1/0, then 0/1) -> applied OVFen=0, UNFen=1.
- Assert rst asynchronously mid-stream -> all outputs 0 immediately; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/round_share_arb.sv
// Round-robin front end for a shared normalize/round datapath: arbitration, in-flight ID tags,
// and drained OVFen/UNFen updates. Define RND_ARB_PERF_CNT_EN to add grant/stall counters (perf_cnt).
module round_share_arb #(
  parameter int NREQ = 3,
  parameter int ID_W = 2,
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*57-1:0]   fr_in,
  input  logic [NREQ*13-1:0]   er_in,
  input  logic [NREQ-1:0]      db_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 iss_valid,
  output logic [56:0]          iss_fr,
  output logic [12:0]          iss_er,
  output logic                 iss_db,
  output logic [ID_W-1:0]      iss_id,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  input  logic                 flush,
  input  logic                 cfg_we,
  input  logic                 cfg_ovfen,
  input  logic                 cfg_unfen,
  output logic                 OVFen,
  output logic                 UNFen,
  output logic                 busy
`ifdef RND_ARB_PERF_CNT_EN
  ,
  output logic [(NREQ+1)*32-1:0] perf_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic            found;
  logic            grant_now;
  logic [NREQ-1:0] eligible;
  logic [LAT-1:0]  tag_v;
  logic [ID_W-1:0] tag_id [LAT];
  logic            pend_ovf;
  logic            pend_unf;
  int              idx;

  // A requester whose grant is pulsing this cycle still shows req high; masking it avoids a double grant.
  always_comb begin
    eligible = req & ~gnt;
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant_now = found && (state == RUN) && !cfg_we && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      iss_valid <= 1'b0;
      iss_fr    <= '0;
      iss_er    <= '0;
      iss_db    <= 1'b0;
      iss_id    <= '0;
      ptr       <= '0;
    end else begin
      gnt       <= '0;
      iss_valid <= grant_now;
      if (grant_now) begin
        gnt    <= NREQ'(1) << win;
        iss_fr <= fr_in[57*win +: 57];
        iss_er <= er_in[13*win +: 13];
        iss_db <= db_in[win];
        iss_id <= win;
        if (win == ID_W'(NREQ-1)) begin
          ptr <= '0;
        end else begin
          ptr <= win + ID_W'(1);
        end
      end
    end
  end

  // Tags mirror the datapath latency; flush also kills the issue currently presented to the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= iss_valid & ~flush;
      tag_id[0] <= iss_id;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1] & ~flush;
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign res_valid = tag_v[LAT-1];
  assign res_id    = tag_id[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pend_ovf <= 1'b0;
      pend_unf <= 1'b0;
      OVFen    <= 1'b0;
      UNFen    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cfg_we) begin
            pend_ovf <= cfg_ovfen;
            pend_unf <= cfg_unfen;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (cfg_we) begin
            pend_ovf <= cfg_ovfen;
            pend_unf <= cfg_unfen;
          end
          if (flush || !(|tag_v)) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          OVFen <= pend_ovf;
          UNFen <= pend_unf;
          // A write landing in APPLY starts a fresh drain rather than being dropped.
          if (cfg_we) begin
            pend_ovf <= cfg_ovfen;
            pend_unf <= cfg_unfen;
            state    <= DRAIN;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign busy = (|tag_v) || (state != RUN);

`ifdef RND_ARB_PERF_CNT_EN
  logic [31:0] gcnt [NREQ];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        gcnt[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_now && (win == ID_W'(i)) && (gcnt[i] != 32'hFFFF_FFFF)) begin
          gcnt[i] <= gcnt[i] + 32'd1;
        end
      end
      if ((|req) && !grant_now && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      perf_cnt[32*i +: 32] = gcnt[i];
    end
    perf_cnt[32*NREQ +: 32] = stall_cnt;
  end
`endif

endmodule

// File: tb/tb_round_share_arb.sv
// Bench for round_share_arb: per-scenario tasks with inline checks and a result-tag scoreboard
// that expects each issued ID to come back exactly LAT cycles after its grant.
module tb_round_share_arb;

  localparam int NREQ = 3;
  localparam int ID_W = 2;
  localparam int LAT  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*57-1:0]  fr_in = '0;
  logic [NREQ*13-1:0]  er_in = '0;
  logic [NREQ-1:0]     db_in = '0;
  logic [NREQ-1:0]     gnt;
  logic                iss_valid;
  logic [56:0]         iss_fr;
  logic [12:0]         iss_er;
  logic                iss_db;
  logic [ID_W-1:0]     iss_id;
  logic                res_valid;
  logic [ID_W-1:0]     res_id;
  logic                flush = 1'b0;
  logic                cfg_we = 1'b0;
  logic                cfg_ovfen = 1'b0;
  logic                cfg_unfen = 1'b0;
  logic                OVFen;
  logic                UNFen;
  logic                busy;
`ifdef RND_ARB_PERF_CNT_EN
  logic [(NREQ+1)*32-1:0] perf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_id_q[$];
  int exp_cyc_q[$];

  round_share_arb #(.NREQ(NREQ), .ID_W(ID_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .fr_in(fr_in), .er_in(er_in), .db_in(db_in),
    .gnt(gnt), .iss_valid(iss_valid), .iss_fr(iss_fr), .iss_er(iss_er), .iss_db(iss_db),
    .iss_id(iss_id), .res_valid(res_valid), .res_id(res_id), .flush(flush),
    .cfg_we(cfg_we), .cfg_ovfen(cfg_ovfen), .cfg_unfen(cfg_unfen),
    .OVFen(OVFen), .UNFen(UNFen), .busy(busy)
`ifdef RND_ARB_PERF_CNT_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [56:0] fr_of(input int i);
    return 57'h0AB_CDEF_1234_5678 + 57'(i) * 57'h1_0101;
  endfunction

  function automatic logic [12:0] er_of(input int i);
    return 13'h0400 + 13'(i) * 13'h0011;
  endfunction

  function automatic logic db_of(input int i);
    return (i == 1);
  endfunction

  // Scoreboard: every result leaving the datapath must match the oldest outstanding grant.
  always @(negedge clk) begin
    int eid;
    int ec;
    if (!rst && res_valid) begin
      checks++;
      if (exp_id_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL res_unexpected: got res_id=%0d at cycle %0d, required no result", res_id, cyc);
      end else begin
        eid = exp_id_q.pop_front();
        ec  = exp_cyc_q.pop_front();
        if (res_id !== ID_W'(eid) || cyc != ec) begin
          errors++;
          $display("[TB] FAIL res_tag: got id=%0d cycle=%0d, required id=%0d cycle=%0d", res_id, cyc, eid, ec);
        end
      end
    end
  end

  task automatic push_expect(input int id);
    exp_id_q.push_back(id);
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (exp_id_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || iss_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_grant: got gnt=%b iss_valid=%b, required 000/0", gnt, iss_valid);
    end
    checks++;
    if (iss_fr !== 57'd0 || iss_er !== 13'd0 || iss_db !== 1'b0 || iss_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_issue: got fr=%h er=%h db=%b id=%0d, required all 0", iss_fr, iss_er, iss_db, iss_id);
    end
    checks++;
    if (res_valid !== 1'b0 || res_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_result: got res_valid=%b res_id=%0d, required 0/0", res_valid, res_id);
    end
    checks++;
    if (OVFen !== 1'b0 || UNFen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cfg: got OVFen=%b UNFen=%b busy=%b, required 0/0/0", OVFen, UNFen, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int id;
    logic [2:0] expg;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      id = k % 3;
      expg = 3'b001 << id;
      checks++;
      if (gnt !== expg || iss_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_gnt[%0d]: got gnt=%b iss_valid=%b, required %b/1", k, gnt, iss_valid, expg);
      end
      checks++;
      if (iss_id !== ID_W'(id) || iss_fr !== fr_of(id) || iss_er !== er_of(id) || iss_db !== db_of(id)) begin
        errors++;
        $display("[TB] FAIL rr_operands[%0d]: got id=%0d fr=%h er=%h db=%b, required id=%0d fr=%h er=%h db=%b",
                 k, iss_id, iss_fr, iss_er, iss_db, id, fr_of(id), er_of(id), db_of(id));
      end
      push_expect(id);
    end
    req = 3'b000;
    drain_wait();
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_drain: got %0d results outstanding, required 0", exp_id_q.size());
    end
  endtask

  task automatic test_single_requester();
    logic [56:0] cur;
    logic [2:0] expg;
    cur = fr_of(0);
    req = 3'b001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      expg = (k % 2 == 0) ? 3'b001 : 3'b000;
      checks++;
      if (gnt !== expg || iss_valid !== expg[0]) begin
        errors++;
        $display("[TB] FAIL single_gnt[%0d]: got gnt=%b iss_valid=%b, required %b/%b", k, gnt, iss_valid, expg, expg[0]);
      end
      if (expg[0]) begin
        checks++;
        if (iss_fr !== cur || iss_id !== 2'd0) begin
          errors++;
          $display("[TB] FAIL single_fr[%0d]: got fr=%h id=%0d, required fr=%h id=0", k, iss_fr, iss_id, cur);
        end
        push_expect(0);
        cur = 57'({$urandom(), $urandom()});
        fr_in[56:0] = cur;
      end
    end
    req = 3'b000;
    fr_in[56:0] = fr_of(0);
    drain_wait();
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL single_drain: got %0d results outstanding, required 0", exp_id_q.size());
    end
  endtask

  task automatic test_flush();
    int pulses;
    int id;
    logic [2:0] expg;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      id = (k + 1) % 3;
      expg = 3'b001 << id;
      checks++;
      if (gnt !== expg) begin
        errors++;
        $display("[TB] FAIL flush_pre_gnt[%0d]: got gnt=%b, required %b", k, gnt, expg);
      end
    end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || iss_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_cycle: got gnt=%b iss_valid=%b busy=%b, required 000/0/0", gnt, iss_valid, busy);
    end
    flush = 1'b0;
    req = 3'b000;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL flush_results: got %0d res_valid pulses, required 0", pulses);
    end
  endtask

  task automatic test_cfg_drain();
    logic [2:0] expg;
    logic expcfg;
    req = 3'b111;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      expg = (k == 1) ? 3'b010 : (k == 2) ? 3'b100 : (k == 9) ? 3'b001 : 3'b000;
      expcfg = (k >= 8);
      checks++;
      if (gnt !== expg) begin
        errors++;
        $display("[TB] FAIL cfg_gnt[%0d]: got gnt=%b, required %b", k, gnt, expg);
      end
      checks++;
      if (OVFen !== expcfg || UNFen !== expcfg) begin
        errors++;
        $display("[TB] FAIL cfg_apply[%0d]: got OVFen=%b UNFen=%b, required %b/%b", k, OVFen, UNFen, expcfg, expcfg);
      end
      if (k >= 3 && k <= 8) begin
        checks++;
        if (busy !== (k <= 7)) begin
          errors++;
          $display("[TB] FAIL cfg_busy[%0d]: got busy=%b, required %b", k, busy, (k <= 7));
        end
      end
      if (k == 1) push_expect(1);
      if (k == 2) begin
        push_expect(2);
        cfg_we = 1'b1;
        cfg_ovfen = 1'b1;
        cfg_unfen = 1'b1;
      end
      if (k == 3) cfg_we = 1'b0;
      if (k == 9) begin
        push_expect(0);
        req = 3'b000;
      end
    end
    drain_wait();
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL cfg_drain: got %0d results outstanding, required 0", exp_id_q.size());
    end
  endtask

  task automatic test_cfg_last_write();
    cfg_we = 1'b1;
    cfg_ovfen = 1'b1;
    cfg_unfen = 1'b0;
    @(negedge clk);
    checks++;
    if (OVFen !== 1'b1 || UNFen !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lww_drain: got OVFen=%b UNFen=%b busy=%b, required 1/1/1", OVFen, UNFen, busy);
    end
    cfg_ovfen = 1'b0;
    cfg_unfen = 1'b1;
    @(negedge clk);
    checks++;
    if (OVFen !== 1'b1 || UNFen !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lww_apply: got OVFen=%b UNFen=%b busy=%b, required 1/1/1", OVFen, UNFen, busy);
    end
    cfg_we = 1'b0;
    @(negedge clk);
    checks++;
    if (OVFen !== 1'b0 || UNFen !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lww_result: got OVFen=%b UNFen=%b busy=%b, required 0/1/0", OVFen, UNFen, busy);
    end
  endtask

  task automatic test_async_reset();
    req = 3'b111;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("[TB] FAIL areset_pre_gnt: got gnt=%b, required 010", gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b000 || iss_valid !== 1'b0 || iss_fr !== 57'd0 || iss_er !== 13'd0 ||
        iss_db !== 1'b0 || iss_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL areset_issue: got gnt=%b iss_valid=%b fr=%h er=%h db=%b id=%0d, required all 0",
               gnt, iss_valid, iss_fr, iss_er, iss_db, iss_id);
    end
    checks++;
    if (res_valid !== 1'b0 || res_id !== 2'd0 || OVFen !== 1'b0 || UNFen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_state: got res_valid=%b res_id=%0d OVFen=%b UNFen=%b busy=%b, required all 0",
               res_valid, res_id, OVFen, UNFen, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001 || iss_fr !== fr_of(0)) begin
      errors++;
      $display("[TB] FAIL areset_first_gnt: got gnt=%b fr=%h, required 001 fr=%h", gnt, iss_fr, fr_of(0));
    end
    push_expect(0);
    req = 3'b000;
    drain_wait();
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL areset_drain: got %0d results outstanding, required 0", exp_id_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      fr_in[57*i +: 57] = fr_of(i);
      er_in[13*i +: 13] = er_of(i);
      db_in[i] = db_of(i);
    end
    test_reset();
    test_round_robin();
    test_single_requester();
    test_flush();
    test_cfg_drain();
    test_cfg_last_write();
    test_async_reset();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running at time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
